// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency busy counter, HI/LO registers, mfhi/mflo/mthi/mtlo
// and pipeline stall. Define MDU_DIV_EN to include div/divu; otherwise they decode as no-ops.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_D,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic        start,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] mdu_out
);

  typedef struct packed {
    logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
  } dec_t;

  function automatic dec_t f_dec(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    if (op == 6'b000000) begin
      case (fn)
        6'b011000: d.mult  = 1'b1;
        6'b011001: d.multu = 1'b1;
`ifdef MDU_DIV_EN
        6'b011010: d.div   = 1'b1;
        6'b011011: d.divu  = 1'b1;
`endif
        6'b010000: d.mfhi  = 1'b1;
        6'b010010: d.mflo  = 1'b1;
        6'b010001: d.mthi  = 1'b1;
        6'b010011: d.mtlo  = 1'b1;
        default: ;
      endcase
    end
    return d;
  endfunction

  dec_t        w_e, w_d;
  logic        w_e_md, w_unused;
  logic [3:0]  w_lat;

  assign w_e      = f_dec(instr_E[31:26], instr_E[5:0]);
  assign w_d      = f_dec(instr_D[31:26], instr_D[5:0]);
  assign w_unused = ^{instr_E[25:6], instr_D[25:6]};
  assign w_e_md   = w_e.mult | w_e.multu | w_e.div | w_e.divu;
  assign w_lat    = (w_e.div | w_e.divu) ? 4'(DIV_LAT) : 4'(MULT_LAT);

  logic [3:0]  r_cnt;
  logic        r_uns;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  assign busy      = (r_cnt != 4'd0);
  assign start     = w_e_md & ~busy;
  assign stall_mdu = (|w_d) & (start | busy);
  assign mdu_out   = w_e.mfhi ? r_hi : (w_e.mflo ? r_lo : 32'd0);

  // Sign-extending both operands lets one 64-bit multiplier serve mult and multu.
  logic [63:0] w_prod;
  assign w_prod = {{32{~r_uns & r_a[31]}}, r_a} * {{32{~r_uns & r_b[31]}}, r_b};

`ifdef MDU_DIV_EN
  logic        r_div;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;

  // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_neg = ~r_uns & r_a[31];
  assign w_b_neg = ~r_uns & r_b[31];
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;
  assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag / w_b_mag;
  assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag % w_b_mag;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;
`endif

  logic        w_commit;
  logic [31:0] w_res_hi, w_res_lo;

  always_comb begin
    w_commit = (r_cnt == 4'd1);
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
`ifdef MDU_DIV_EN
    if (r_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
      if (r_b == 32'd0) w_commit = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_uns <= 1'b0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (start) begin
        r_cnt <= w_lat;
        r_a   <= rs_E;
        r_b   <= rt_E;
        r_uns <= w_e.multu | w_e.divu;
      end else if (busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (!busy) begin
        if (w_e.mthi) r_hi <= rs_E;
        if (w_e.mtlo) r_lo <= rs_E;
      end
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_div <= 1'b0;
    else if (start) r_div <= w_e.div | w_e.divu;
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random ops against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
  localparam int ML = 5;
  localparam int DL = 10;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                         F_MTHI = 6'b010001, F_MTLO = 6'b010011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_E, instr_D, rs_E, rt_E, mdu_out;
  logic        start, busy, stall_mdu;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .instr_E(instr_E), .instr_D(instr_D),
    .rs_E(rs_E), .rt_E(rt_E), .start(start), .busy(busy),
    .stall_mdu(stall_mdu), .mdu_out(mdu_out)
  );

  function automatic logic [31:0] R(input logic [5:0] fn);
    return {26'b0, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural MIPS semantics in wide integer arithmetic.
  task automatic model_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      F_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      F_DIV:   if (b != 0) begin
                 q = sa / sb; r = sa % sb;
                 p = 64'(q); m_lo = p[31:0];
                 p = 64'(r); m_hi = p[31:0];
               end
      F_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic rd(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    instr_E = R(F_MFHI); #1;
    chk({tag, "_hi"}, mdu_out, ehi);
    instr_E = R(F_MFLO); #1;
    chk({tag, "_lo"}, mdu_out, elo);
    instr_E = 32'd0; #1;
  endtask

  task automatic run(input string tag, input logic [5:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input int lat);
    int n;
    instr_E = R(fn); rs_E = a; rt_E = b; #1;
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    model_op(fn, a, b);
    step;
    instr_E = 32'd0; rs_E = $urandom; rt_E = $urandom;
    n = 0;
    while (busy && n < 20) begin n++; step; end
    chk({tag, "_busycyc"}, n, lat);
  endtask

  task automatic mt(input logic [5:0] fn, input logic [31:0] v);
    instr_E = R(fn); rs_E = v; step;
    if (fn == F_MTHI) m_hi = v; else m_lo = v;
    instr_E = 32'd0;
  endtask

  initial begin
    int n;
    logic [5:0]  fn;
    logic [31:0] a, b;
    reset = 1'b1; instr_E = 32'd0; instr_D = 32'd0; rs_E = 32'd0; rt_E = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    step; step;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    instr_E = R(F_MULT); instr_D = R(F_MFHI); #1;
    chk("rst_start_comb", {31'd0, start}, 32'd1);
    chk("rst_stall_comb", {31'd0, stall_mdu}, 32'd1);
    instr_E = 32'd0; instr_D = 32'd0; #1;
    reset = 1'b0;
    rd("rst_val", 32'd0, 32'd0);

    run("mult", F_MULT, 32'hFFFFFFFF, 32'd2, ML);
    rd("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, ML);
    rd("multu", 32'h00000001, 32'hFFFFFFFE);

    // second start and mthi during busy are both ignored
    instr_E = R(F_MULT); rs_E = 32'd3; rt_E = 32'd4; #1;
    model_op(F_MULT, 32'd3, 32'd4);
    step;
    instr_E = R(F_MULTU); rs_E = 32'd100; rt_E = 32'd100; #1;
    chk("busy_start_blocked", {31'd0, start}, 32'd0);
    step;
    instr_E = R(F_MTHI); rs_E = 32'hDEADBEEF; step;
    instr_E = 32'd0;
    n = 2;
    while (busy && n < 20) begin n++; step; end
    chk("no_reload_busycyc", n, ML);
    rd("no_reload", 32'd0, 32'd12);

    // stall: mult in E with mflo in D
    instr_D = R(F_MFLO); instr_E = R(F_MULT); rs_E = 32'd7; rt_E = 32'hFFFFFFFD; #1;
    model_op(F_MULT, 32'd7, 32'hFFFFFFFD);
    n = 0;
    if (stall_mdu) n++;
    step;
    instr_E = 32'd0;
    while (stall_mdu && n < 20) begin n++; step; end
    chk("stall_cycles", n, ML + 1);
    instr_D = 32'd0; instr_E = R(F_MFLO); #1;
    chk("stall_mflo", mdu_out, 32'hFFFFFFEB);
    instr_E = 32'd0;

    mt(F_MTHI, 32'h12345678);
    mt(F_MTLO, 32'h9ABCDEF0);
    rd("mt", 32'h12345678, 32'h9ABCDEF0);

`ifdef MDU_DIV_EN
    run("div", F_DIV, 32'hFFFFFFF9, 32'd2, DL);
    rd("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    mt(F_MTHI, 32'h12345678);
    run("div0", F_DIV, 32'd55, 32'd0, DL);
    rd("div0", 32'h12345678, m_lo);
    run("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, DL);
    rd("divovf", 32'd0, 32'h80000000);
    run("divu", F_DIVU, 32'hFFFFFFF9, 32'd2, DL);
    rd("divu", 32'd1, 32'h7FFFFFFC);
`else
    instr_D = R(F_DIVU); instr_E = R(F_DIVU); rs_E = 32'd10; rt_E = 32'd3; #1;
    chk("nodiv_start", {31'd0, start}, 32'd0);
    chk("nodiv_stall", {31'd0, stall_mdu}, 32'd0);
    step;
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    instr_D = 32'd0; instr_E = 32'd0;
    rd("nodiv", 32'h12345678, 32'h9ABCDEF0);
`endif

    for (int i = 0; i < 16; i++) begin
`ifdef MDU_DIV_EN
      case ($urandom_range(3))
        0: fn = F_MULT; 1: fn = F_MULTU; 2: fn = F_DIV; default: fn = F_DIVU;
      endcase
`else
      fn = ($urandom_range(1) == 0) ? F_MULT : F_MULTU;
`endif
      a = $urandom; b = $urandom;
      if ($urandom_range(7) == 0) b = 32'd0;
      if ($urandom_range(7) == 0) a = 32'h80000000;
      run($sformatf("rnd%0d", i), fn, a, b, (fn == F_DIV || fn == F_DIVU) ? DL : ML);
      rd($sformatf("rnd%0d", i), m_hi, m_lo);
    end

    // reset in the 3rd busy cycle of multu 3x3
    run("pre_rst", F_MULTU, 32'd5, 32'd5, ML);
    instr_E = R(F_MULTU); rs_E = 32'd3; rt_E = 32'd3; step;
    instr_E = 32'd0; step; step;
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    step;
    reset = 1'b0;
    rd("rst_mid", 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) step;
    chk("rst_no_commit_busy", {31'd0, busy}, 32'd0);
    rd("rst_no_commit", 32'd0, 32'd0);

    run("post_rst", F_MULTU, 32'd3, 32'd3, ML);
    rd("post_rst", 32'd0, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
